// File: rtl/mem_dma_pkg.sv
// mem_dma shared definitions: register map,
// CTRL bit positions and FSM state encoding.
package mem_dma_pkg;

  localparam logic [3:0] REG_SRC  = 4'd0;
  localparam logic [3:0] REG_DST  = 4'd1;
  localparam logic [3:0] REG_LEN  = 4'd2;
  localparam logic [3:0] REG_CTRL = 4'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_DONE   = 1;
  localparam int CTRL_ABORT  = 2;
  localparam int CTRL_IRQ_EN = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_GAP_W,
    ST_WRITE,
    ST_GAP_R
  } state_t;

endpackage

// File: rtl/mem_dma.sv
// Word-copy DMA: register responder for the CPU,
// valid/ready bus initiator doing read-then-write per word.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [3:0]  s_addr,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  output logic        s_ready,
  output logic [31:0] s_rdata,
  output logic        m_valid,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_ready,
  input  logic [31:0] m_rdata,
  output logic        irq
);

  state_t state, state_d;

  logic [31:0]      src, dst, buf_q, rd_mux;
  logic [LEN_W-1:0] len;
  logic done, irq_en, abort_pend, s_ready_q;
  logic busy, rd_fire, wr, wr_ctrl;
  logic wr_src, wr_dst, wr_len;
  logic start_go, abort_go;
  logic rd_done, wr_done, last, finish;

  logic        m_valid_d;
  logic [31:0] m_addr_d, m_wdata_d;
  logic [3:0]  m_wstrb_d;

  assign busy     = state != ST_IDLE;
  assign s_ready  = s_ready_q;
  assign rd_fire  = s_valid & ~s_ready_q;
  assign wr       = s_valid & s_ready_q & (|s_wstrb);
  assign wr_src   = wr & (s_addr == REG_SRC) & ~busy;
  assign wr_dst   = wr & (s_addr == REG_DST) & ~busy;
  assign wr_len   = wr & (s_addr == REG_LEN) & ~busy;
  assign wr_ctrl  = wr & (s_addr == REG_CTRL);
  assign start_go = wr_ctrl & s_wdata[CTRL_START] & ~busy;
  assign abort_go = wr_ctrl & s_wdata[CTRL_ABORT] & busy;
  assign rd_done  = (state == ST_READ) & m_ready;
  assign wr_done  = (state == ST_WRITE) & m_ready;
  assign last     = (len == '0) | abort_pend;
  assign finish   = (state == ST_GAP_R) & last;
  assign irq      = done & irq_en;

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (s_addr == REG_SRC):  rd_mux = src;
      (s_addr == REG_DST):  rd_mux = dst;
      (s_addr == REG_LEN):  rd_mux[LEN_W-1:0] = len;
      (s_addr == REG_CTRL): rd_mux[3:0] = {irq_en, 1'b0, done, busy};
      default:              rd_mux = '0;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // zero-length start walks through GAP_R so DONE lands like a real copy
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (start_go)
                  state_d = (len == '0) ? ST_GAP_R : ST_READ;
      ST_READ:  if (m_ready) state_d = ST_GAP_W;
      ST_GAP_W: state_d = ST_WRITE;
      ST_WRITE: if (m_ready) state_d = ST_GAP_R;
      ST_GAP_R: state_d = last ? ST_IDLE : ST_READ;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_valid_d = (state_d == ST_READ) | (state_d == ST_WRITE);
    m_addr_d  = '0;
    m_wdata_d = '0;
    m_wstrb_d = '0;
    if (state_d == ST_READ) begin
      m_addr_d = src;
    end else if (state_d == ST_WRITE) begin
      m_addr_d  = dst;
      m_wdata_d = buf_q;
      m_wstrb_d = 4'hF;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_wstrb <= '0;
    end else begin
      m_valid <= m_valid_d;
      m_addr  <= m_addr_d;
      m_wdata <= m_wdata_d;
      m_wstrb <= m_wstrb_d;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      s_ready_q <= 1'b0;
      s_rdata   <= '0;
    end else begin
      s_ready_q <= rd_fire;
      s_rdata   <= rd_fire ? rd_mux : '0;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      buf_q      <= '0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if (wr_src)       src <= {s_wdata[31:2], 2'b00};
      else if (wr_done) src <= src + 32'd4;
      if (wr_dst)       dst <= {s_wdata[31:2], 2'b00};
      else if (wr_done) dst <= dst + 32'd4;
      if (wr_len)       len <= s_wdata[LEN_W-1:0];
      else if (wr_done) len <= len - LEN_W'(1);
      if (rd_done)      buf_q <= m_rdata;
      if (wr_ctrl)      irq_en <= s_wdata[CTRL_IRQ_EN];
      if (finish)       done <= 1'b1;
      else if (wr_ctrl && s_wdata[CTRL_DONE])
        done <= 1'b0;
      if (state_d == ST_IDLE) abort_pend <= 1'b0;
      else if (abort_go)      abort_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_dma.sv
// Scoreboard bench for mem_dma: 1-wait memory responder,
// expected bus transactions queued at start, checked on ready.
module tb_mem_dma;

  logic        mem_clk, rst_n;
  logic        s_valid, s_ready;
  logic [3:0]  s_addr, s_wstrb;
  logic [31:0] s_wdata, s_rdata;
  logic        m_valid, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        irq;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  int   n_cmp, n_err;
  logic stall;

  mem_dma #(.LEN_W(16)) dut (
    .mem_clk(mem_clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .irq(irq)
  );

  initial begin
    mem_clk = 1'b0;
    forever #5 mem_clk = ~mem_clk;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  // 1-wait responder: ready one cycle after valid, dropped next cycle
  initial begin
    int   cnt;
    txn_t e;
    cnt = 0;
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge mem_clk); #1;
      if (m_ready) begin
        m_ready = 1'b0;
        cnt = 0;
        chk("gap", 64'(m_valid), 64'd0);
      end else if (m_valid && !stall) begin
        if (cnt == 0) cnt = 1;
        else begin
          m_ready = 1'b1;
          if (m_wstrb == 4'h0) m_rdata = pat(m_addr);
          if (exp_q.size() == 0) begin
            chk("txn_extra", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            chk("txn_addr", 64'(m_addr), 64'(e.addr));
            chk("txn_strb", 64'(m_wstrb), 64'(e.wstrb));
            if (e.wstrb != 4'h0)
              chk("txn_data", 64'(m_wdata), 64'(e.data));
          end
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    bit ok;
    ok = 0;
    s_valid = 1'b1; s_addr = a; s_wdata = d; s_wstrb = 4'hF;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge mem_clk); #1;
      if (s_ready) ok = 1;
    end
    if (!ok) chk("s_ready_wr", 64'(ok), 64'd1);
    @(posedge mem_clk); #1;
    s_valid = 1'b0; s_wstrb = 4'h0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d);
    bit ok;
    ok = 0;
    d = '0;
    s_valid = 1'b1; s_addr = a; s_wstrb = 4'h0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge mem_clk); #1;
      if (s_ready) begin ok = 1; d = s_rdata; end
    end
    if (!ok) chk("s_ready_rd", 64'(ok), 64'd1);
    @(posedge mem_clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d,
                           input int words);
    txn_t t;
    for (int i = 0; i < words; i++) begin
      t.addr = s + 32'(4 * i); t.wstrb = 4'h0; t.data = '0;
      exp_q.push_back(t);
      t.addr = d + 32'(4 * i); t.wstrb = 4'hF; t.data = pat(s + 32'(4 * i));
      exp_q.push_back(t);
    end
  endtask

  task automatic setup(input logic [31:0] s, input logic [31:0] d,
                       input logic [31:0] l);
    cfg_write(4'd0, s);
    cfg_write(4'd1, d);
    cfg_write(4'd2, l);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] r;
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      cfg_read(4'd3, r);
      if (r[0] == 1'b0) ok = 1;
    end
    if (!ok) chk(tag, 64'(r[0]), 64'd0);
  endtask

  task automatic wait_irq(input string tag, output int n);
    n = 0;
    while (!irq && n < 200) begin
      @(posedge mem_clk); #1;
      n++;
    end
    if (!irq) chk(tag, 64'(irq), 64'd1);
  endtask

  initial begin
    logic [31:0] r;
    int n, bad;
    n_cmp = 0; n_err = 0; stall = 1'b0;
    rst_n = 1'b0; s_valid = 1'b0; s_addr = '0;
    s_wdata = '0; s_wstrb = '0;
    repeat (3) @(posedge mem_clk);
    #1 rst_n = 1'b1;

    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_m_wdata", 64'(m_wdata), 64'd0);
    chk("rst_m_wstrb", 64'(m_wstrb), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cfg_read(4'(i), r);
      chk("rst_reg", 64'(r), 64'd0);
    end

    // basic 4-word copy with timing
    setup(32'h100, 32'h200, 32'd4);
    push_copy(32'h100, 32'h200, 4);
    cfg_write(4'd3, 32'h9);
    chk("start_lat", 64'(m_valid), 64'd1);
    wait_irq("irq_to_1", n);
    chk("cyc_to_done", 64'(n), 64'd24);
    chk("q_empty_1", 64'(exp_q.size()), 64'd0);
    cfg_read(4'd3, r);
    chk("ctrl_done_1", 64'(r), 64'hA);
    cfg_read(4'd0, r);
    chk("src_end_1", 64'(r), 64'h110);
    cfg_read(4'd2, r);
    chk("len_end_1", 64'(r), 64'd0);
    cfg_write(4'd3, 32'h2);
    cfg_read(4'd3, r);
    chk("ctrl_clr_1", 64'(r), 64'd0);

    // zero-length start
    cfg_write(4'd3, 32'h9);
    chk("len0_irq_early", 64'(irq), 64'd0);
    @(posedge mem_clk); #1;
    chk("len0_irq", 64'(irq), 64'd1);
    cfg_read(4'd2, r);
    chk("len0_len", 64'(r), 64'd0);
    cfg_read(4'd0, r);
    chk("len0_src", 64'(r), 64'h110);
    cfg_read(4'd1, r);
    chk("len0_dst", 64'(r), 64'h210);
    cfg_write(4'd3, 32'h2);

    // abort during the third word's read
    setup(32'h1000, 32'h2000, 32'd10);
    push_copy(32'h1000, 32'h2000, 3);
    cfg_write(4'd3, 32'h9);
    n = 0;
    while (!(m_valid && m_wstrb == 4'h0 && m_addr == 32'h1008) && n < 100) begin
      @(posedge mem_clk); #1;
      n++;
    end
    if (n >= 100) chk("abort_seek", 64'(m_addr), 64'h1008);
    cfg_write(4'd3, 32'hC);
    wait_irq("irq_to_ab", n);
    cfg_read(4'd2, r);
    chk("ab_len", 64'(r), 64'd7);
    cfg_read(4'd0, r);
    chk("ab_src", 64'(r), 64'h100C);
    cfg_read(4'd1, r);
    chk("ab_dst", 64'(r), 64'h200C);
    cfg_read(4'd3, r);
    chk("ab_ctrl", 64'(r), 64'hA);
    chk("ab_irq", 64'(irq), 64'd1);
    cfg_write(4'd3, 32'hA);
    chk("ab_irq_clr", 64'(irq), 64'd0);
    chk("q_empty_ab", 64'(exp_q.size()), 64'd0);

    // source address wrap
    setup(32'hFFFF_FFF8, 32'h300, 32'd3);
    push_copy(32'hFFFF_FFF8, 32'h300, 3);
    cfg_write(4'd3, 32'h1);
    wait_idle("idle_to_wrap");
    chk("q_empty_wrap", 64'(exp_q.size()), 64'd0);
    cfg_read(4'd0, r);
    chk("wrap_src", 64'(r), 64'h4);
    cfg_write(4'd3, 32'h2);

    // busy-time writes and a stalled responder
    stall = 1'b1;
    setup(32'h400, 32'h500, 32'd2);
    push_copy(32'h400, 32'h500, 2);
    cfg_write(4'd3, 32'h1);
    cfg_write(4'd0, 32'h5);
    cfg_write(4'd3, 32'h1);
    cfg_read(4'd3, r);
    chk("busy_ctrl", 64'(r), 64'h1);
    cfg_read(4'd0, r);
    chk("busy_src", 64'(r), 64'h400);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!m_valid || m_addr !== 32'h400 || m_wstrb !== 4'h0) bad++;
      @(posedge mem_clk); #1;
    end
    chk("stall_stable", 64'(bad), 64'd0);
    stall = 1'b0;
    wait_idle("idle_to_busy");
    chk("q_empty_busy", 64'(exp_q.size()), 64'd0);
    cfg_read(4'd0, r);
    chk("busy_src_end", 64'(r), 64'h408);
    cfg_write(4'd3, 32'h2);

    // reset asserted mid-write
    setup(32'h600, 32'h700, 32'd5);
    push_copy(32'h600, 32'h700, 1);
    void'(exp_q.pop_back());
    cfg_write(4'd3, 32'h9);
    n = 0;
    while (!(m_valid && m_wstrb == 4'hF) && n < 100) begin
      @(posedge mem_clk); #1;
      n++;
    end
    if (n >= 100) chk("rw_seek", 64'(m_wstrb), 64'hF);
    rst_n = 1'b0;
    @(posedge mem_clk); #1;
    rst_n = 1'b1;
    chk("rw_m_valid", 64'(m_valid), 64'd0);
    chk("rw_m_wstrb", 64'(m_wstrb), 64'd0);
    chk("rw_m_addr", 64'(m_addr), 64'd0);
    chk("rw_irq", 64'(irq), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cfg_read(4'(i), r);
      chk("rw_reg", 64'(r), 64'd0);
    end
    chk("q_empty_rw", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
